// File: rtl/conware_pkg.sv
// Shared definitions for the conware pipeline: FSM state encoding, default
// grid geometry and the index-width helper used to size the pixel counter.
package conware_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_HEIGHT = 32;
  localparam int unsigned CELLS      = DEF_WIDTH * DEF_HEIGHT;

  // Bits needed to address every cell; a single-cell grid still needs one bit.
  function automatic int unsigned idx_width(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/conware_frame_tx.sv
// Frame transmitter: snapshots one generation of cell states plus the two
// colours, then streams the frame as an AXI4-Stream master, one pixel per
// beat in raster order, TLAST on the final pixel.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request a frame (honoured only while idle)
//   states           WIDTH*HEIGHT cell bits, bit i = row i/WIDTH, col i%WIDTH
//   alive_color      pixel value for live cells
//   dead_color       pixel value for dead cells
//   busy             frame in progress
//   done             one-cycle pulse after the last beat is accepted
//   frame_count      completed frames, wraps at 16 bits
//   M_AXIS_*         AXI4-Stream master (TVALID/TREADY/TDATA/TLAST)
module conware_frame_tx
  import conware_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   states,
  input  logic [DWIDTH-1:0]         alive_color,
  input  logic [DWIDTH-1:0]         dead_color,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               frame_count,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST
);

  localparam int unsigned NCELLS = WIDTH * HEIGHT;
  localparam int unsigned IW     = idx_width(NCELLS);
  localparam logic [IW-1:0] LAST = IW'(NCELLS - 1);

  state_t              state;
  logic [NCELLS-1:0]   snap;
  logic [DWIDTH-1:0]   alive_q;
  logic [DWIDTH-1:0]   dead_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic                handshake;

  assign idx_nxt   = idx + IW'(1);
  assign handshake = M_AXIS_TVALID & M_AXIS_TREADY;

  // FSM, snapshot, index counter and colour mux. TDATA/TLAST are loaded one
  // pixel ahead so they are valid in the same cycle TVALID rises or advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      snap          <= '0;
      alive_q       <= '0;
      dead_q        <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_count   <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap          <= states;
            alive_q       <= alive_color;
            dead_q        <= dead_color;
            idx           <= '0;
            state         <= SEND;
            busy          <= 1'b1;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= states[0] ? alive_color : dead_color;
            M_AXIS_TLAST  <= 1'(NCELLS == 1);
          end
        end
        SEND: begin
          if (handshake) begin
            if (idx == LAST) begin
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              frame_count   <= frame_count + 16'd1;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
            end else begin
              idx          <= idx_nxt;
              M_AXIS_TDATA <= snap[idx_nxt] ? alive_q : dead_q;
              M_AXIS_TLAST <= (idx_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conware_frame_tx.sv
// Directed bench for conware_frame_tx on a 2x2 grid.
module tb_conware_frame_tx;

  localparam int unsigned DW = 32;
  localparam logic [31:0] ALIVE = 32'h00FF_FFFF;
  localparam logic [31:0] DEAD  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  states;
  logic [31:0] alive_color;
  logic [31:0] dead_color;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conware_frame_tx #(.DWIDTH(DW), .WIDTH(2), .HEIGHT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .states        (states),
    .alive_color   (alive_color),
    .dead_color    (dead_color),
    .busy          (busy),
    .done          (done),
    .frame_count   (frame_count),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast)
  );

  // Runs one 4-beat frame. tready follows pat (LSB first, plen entries).
  // pre: start was already driven in the previous done cycle.
  // perturb: change states/colours one cycle after start.
  // poke: pulse start during the second beat cycle (must be ignored).
  // chain: drive start in the done cycle for an immediate next frame.
  task automatic run_frame(input string tag, input logic [3:0] st,
                           input logic [7:0] pat, input int plen,
                           input bit pre, input bit perturb, input bit poke,
                           input bit chain, input logic [15:0] exp_fc);
    logic [31:0] exp_px [4];
    int beats;
    int cyc;
    int hs;
    for (int i = 0; i < 4; i++) exp_px[i] = st[i] ? ALIVE : DEAD;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; states = st; alive_color = ALIVE; dead_color = DEAD;
    end
    @(negedge clk);
    start = 1'b0;
    beats = 0; cyc = 0; hs = 0;
    while (beats < 4 && cyc < 40) begin
      tready = pat[cyc % plen];
      if (perturb && cyc == 0) begin
        states = 4'b1111; alive_color = 32'h1234_5678; dead_color = 32'hDEAD_BEEF;
      end
      start = (poke && cyc == 1);
      n_cmp++;
      if (tvalid !== 1'b1 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s valid/busy beat%0d: got %b/%b want 1/1", tag, beats, tvalid, busy);
      end
      n_cmp++;
      if (tdata !== exp_px[beats]) begin
        n_bad++;
        $display("FAIL %s tdata beat%0d: got %h want %h", tag, beats, tdata, exp_px[beats]);
      end
      n_cmp++;
      if (tlast !== (beats == 3)) begin
        n_bad++;
        $display("FAIL %s tlast beat%0d: got %b want %b", tag, beats, tlast, beats == 3);
      end
      if (tready) begin beats++; hs++; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (beats != 4) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d beats want 4", tag, beats);
    end
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end valid/busy/done: got %b/%b/%b want 0/0/1", tag, tvalid, busy, done);
    end
    n_cmp++;
    if (frame_count !== exp_fc) begin
      n_bad++;
      $display("FAIL %s frame_count: got %0d want %0d", tag, frame_count, exp_fc);
    end
    if (chain) begin
      start = 1'b1; states = st; alive_color = ALIVE; dead_color = DEAD;
    end else begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || tvalid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle after done: done/valid/busy %b/%b/%b want 0/0/0", tag, done, tvalid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tready = 1'b0; states = '0;
    alive_color = ALIVE; dead_color = DEAD;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tvalid, tlast, busy, done} !== 4'b0 || frame_count !== 16'd0 || tdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v%b l%b b%b d%b fc%0d data%h want all 0",
               tvalid, tlast, busy, done, frame_count, tdata);
    end
    rst = 1'b0;
    // TREADY in idle must not start anything
    tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_tready: got valid %b busy %b want 0/0", tvalid, busy);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 4'b0101, 8'hFF, 1, 0, 0, 0, 0, 16'd1);
  endtask

  task automatic test_stall();
    // 1,0,0,1,0,1,1 -> handshakes on cycles 0,3,5,6
    run_frame("stall", 4'b0101, 8'b0110_1001, 7, 0, 0, 0, 0, 16'd2);
  endtask

  task automatic test_snapshot();
    run_frame("snapshot", 4'b0101, 8'hFF, 1, 0, 1, 0, 0, 16'd3);
  endtask

  task automatic test_back_to_back();
    run_frame("busy_start", 4'b0110, 8'hFF, 1, 0, 0, 1, 1, 16'd4);
    run_frame("chained", 4'b0110, 8'hFF, 1, 1, 0, 0, 0, 16'd5);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; states = 4'b0101; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_count !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v%b b%b d%b fc%0d want 0/0/0/0", tvalid, busy, done, frame_count);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_nodone: got done %b valid %b want 0/0", done, tvalid);
    end
    run_frame("after_reset", 4'b1001, 8'hFF, 1, 0, 0, 0, 0, 16'd1);
  endtask

  task automatic test_wrap();
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    run_frame("wrap", 4'b0011, 8'hFF, 1, 0, 0, 0, 0, 16'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
